fwd_hazard_unit: RTL and testbench
==================================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter NSRC, default 2: number of source operands checked per instruction.
REQ-002 Parameter NSTG, default 2: number of forwarding stages; stage 1 is youngest (EX/MEM), stage NSTG is oldest.
REQ-003 Parameter AW, default 5: register address width.
REQ-004 Parameter LD_LAT, default 1, legal range 1..7: load-use stall length in cycles.
REQ-005 Parameter CNT_W, default 16: stall performance counter width.
REQ-006 Derived width SW = $clog2(NSTG+1): forward select width per source.
REQ-007 clk  input  1  sole clock; all state updates on rising edge.
REQ-008 rstn  input  1  reset, asynchronous, active-low.
REQ-009 id_src  input  NSRC*AW  ID/EX source addresses; source i is bits [i*AW +: AW].
REQ-010 id_src_used  input  NSRC  source i is read by the instruction.
REQ-011 id_valid  input  1  ID/EX holds a valid instruction.
REQ-012 stg_rd  input  NSTG*AW  destination address of stage k (k=1..NSTG) at bits [(k-1)*AW +: AW].
REQ-013 stg_wen  input  NSTG  stage k writes the register file.
REQ-014 ld_rd  input  AW  destination of the instruction entering EX.
REQ-015 ld_is_load  input  1  the instruction entering EX is a load.
REQ-016 flush  input  1  pipeline flush (branch/jump taken).
REQ-017 fwd_sel  output  NSRC*SW  per-source select; 0 = register file, k = stage k.
REQ-018 stall  output  1  freeze PC and IF/ID, insert bubble into EX.
REQ-019 perf_stall_cnt  output  CNT_W  total cycles with stall asserted, saturating.

Function
REQ-020 A stage k matches source i only when stg_wen[k]=1, stg_rd(k)!=0 and stg_rd(k)==id_src(i).
REQ-021 fwd_sel(i) SHALL equal the lowest-numbered matching stage, or 0 when no stage matches or id_src_used[i]=0; combinational, zero latency.
REQ-022 Address 0 SHALL never match, even when stg_wen=1.
REQ-023 Load-use hazard = id_valid & ld_is_load & (ld_rd!=0) & (for some i, id_src_used[i] & ld_rd==id_src(i)).
REQ-024 FSM states: IDLE and STALL; 3-bit down-counter cnt.
REQ-025 IDLE: stall = hazard & ~flush (Mealy); on hazard & ~flush with LD_LAT>1, go to STALL with cnt=LD_LAT-2; otherwise remain IDLE.
REQ-026 STALL: stall=1 unconditionally; if cnt==0 go to IDLE, else cnt decrements.
REQ-027 A single hazard SHALL produce exactly LD_LAT consecutive stall cycles; with LD_LAT=1, STALL is never entered.
REQ-028 A new hazard during STALL SHALL be ignored; the stall window is not extended or restarted.
REQ-029 A hazard in the first IDLE cycle after STALL SHALL start a fresh window, giving back-to-back windows.
REQ-030 flush SHALL force stall=0 in the same cycle and IDLE on the next edge, with cnt cleared; flush wins over a simultaneous hazard.
REQ-031 perf_stall_cnt SHALL increment by 1 on each edge where stall=1 and saturate at all-ones without wrapping.
REQ-032 fwd_sel SHALL remain valid and combinational during stall cycles.

Reset
REQ-033 While rstn=0: state IDLE, cnt=0, perf_stall_cnt=0, and no hazard is recorded.
REQ-034 stall is 0 after reset as long as the inputs carry no hazard; fwd_sel depends only on inputs.
REQ-035 Reset asserted mid-STALL SHALL abort the window immediately (asynchronous), without waiting for a clock edge.

Verification
REQ-036 Defaults; stg1 wen=1 rd=5, stg2 wen=1 rd=5, src0=5 used -> fwd_sel0=1; clear stg1 wen -> fwd_sel0=2; src0=0 with stg rd=0 -> 0.
REQ-037 LD_LAT=3; load rd=7, src1=7 used, id_valid -> stall high exactly 3 cycles, perf_stall_cnt 0->3.
REQ-038 LD_LAT=3; hazard, then flush in the second stall cycle -> stall=0 that cycle, IDLE next cycle, perf_stall_cnt=1.
REQ-039 Load rd=7 with id_src_used=0, or ld_rd=0 -> stall never asserts.
REQ-040 CNT_W=4; hold the hazard continuously at LD_LAT=1 for 20 cycles -> perf_stall_cnt stops at 15.
REQ-041 LD_LAT=3; rstn low mid-STALL -> stall=0 and perf_stall_cnt=0 immediately, with no clock edge.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select and load-use stall controller for the ID/EX stage.
// Forward selects and stall are combinational; the stall window and perf counter are registered.
module fwd_hazard_unit #(
   parameter  int unsigned NSRC   = 2,
   parameter  int unsigned NSTG   = 2,
   parameter  int unsigned AW     = 5,
   parameter  int unsigned LD_LAT = 1,
   parameter  int unsigned CNT_W  = 16,
   localparam int unsigned SW     = $clog2(NSTG + 1)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [NSRC*AW-1:0]   id_src,
   input  logic [NSRC-1:0]      id_src_used,
   input  logic                 id_valid,
   input  logic [NSTG*AW-1:0]   stg_rd,
   input  logic [NSTG-1:0]      stg_wen,
   input  logic [AW-1:0]        ld_rd,
   input  logic                 ld_is_load,
   input  logic                 flush,
   output logic [NSRC*SW-1:0]   fwd_sel,
   output logic                 stall,
   output logic [CNT_W-1:0]     perf_stall_cnt
);

   typedef enum logic {S_IDLE, S_STALL} state_e;

   // Remaining-cycle count loaded when a window longer than one cycle opens.
   localparam logic [2:0] CNT_INIT = (LD_LAT > 1) ? 3'(LD_LAT - 2) : 3'd0;

   state_e             state_q, state_d;
   logic [2:0]         cnt_q, cnt_d;
   logic [CNT_W-1:0]   perf_q, perf_d;
   logic               hazard;

   // Youngest matching stage wins: scan oldest to youngest, later writes override.
   always_comb begin
      fwd_sel = '0;
      for (int i = 0; i < int'(NSRC); i++) begin
         for (int k = int'(NSTG); k >= 1; k--) begin
            if (id_src_used[i] && stg_wen[k-1] &&
                (stg_rd[(k-1)*AW +: AW] != '0) &&
                (stg_rd[(k-1)*AW +: AW] == id_src[i*AW +: AW])) begin
               fwd_sel[i*SW +: SW] = SW'(k);
            end
         end
      end
   end

   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < int'(NSRC); i++) begin
         if (id_src_used[i] && (ld_rd == id_src[i*AW +: AW])) begin
            hazard = 1'b1;
         end
      end
      hazard = hazard & id_valid & ld_is_load & (ld_rd != '0);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         perf_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         perf_q  <= perf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = 3'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (hazard && (LD_LAT > 1)) begin
                  state_d = S_STALL;
                  cnt_d   = CNT_INIT;
               end
            end
            S_STALL: begin
               if (cnt_q == 3'd0) begin
                  state_d = S_IDLE;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = 3'd0;
            end
         endcase
      end
   end

   // Flush overrides both an open window and a fresh hazard.
   always_comb begin
      stall  = ~flush & ((state_q == S_STALL) | hazard);
      perf_d = perf_q;
      if (stall && (perf_q != '1)) begin
         perf_d = perf_q + CNT_W'(1);
      end
   end

   assign perf_stall_cnt = perf_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized + directed bench for fwd_hazard_unit against a window-count reference model.
// Two instances share stimulus: LD_LAT=3 and LD_LAT=1, both with a 4-bit perf counter.
module tb_fwd_hazard_unit;

   localparam int unsigned NSRC = 2;
   localparam int unsigned NSTG = 2;
   localparam int unsigned AW   = 5;
   localparam int unsigned CW   = 4;
   localparam int unsigned SW   = $clog2(NSTG + 1);

   logic                 clk;
   logic                 rstn;
   logic [NSRC*AW-1:0]   id_src;
   logic [NSRC-1:0]      id_src_used;
   logic                 id_valid;
   logic [NSTG*AW-1:0]   stg_rd;
   logic [NSTG-1:0]      stg_wen;
   logic [AW-1:0]        ld_rd;
   logic                 ld_is_load;
   logic                 flush;

   logic [NSRC*SW-1:0]   fwd_sel_a, fwd_sel_b;
   logic                 stall_a, stall_b;
   logic [CW-1:0]        perf_a, perf_b;

   int n_checks = 0;
   int n_errors = 0;

   int lat  [2];
   int rem  [2];
   int perf [2];

   fwd_hazard_unit #(.NSRC(NSRC), .NSTG(NSTG), .AW(AW), .LD_LAT(3), .CNT_W(CW)) u_dut_a (
      .clk(clk), .rstn(rstn), .id_src(id_src), .id_src_used(id_src_used),
      .id_valid(id_valid), .stg_rd(stg_rd), .stg_wen(stg_wen), .ld_rd(ld_rd),
      .ld_is_load(ld_is_load), .flush(flush), .fwd_sel(fwd_sel_a), .stall(stall_a),
      .perf_stall_cnt(perf_a)
   );

   fwd_hazard_unit #(.NSRC(NSRC), .NSTG(NSTG), .AW(AW), .LD_LAT(1), .CNT_W(CW)) u_dut_b (
      .clk(clk), .rstn(rstn), .id_src(id_src), .id_src_used(id_src_used),
      .id_valid(id_valid), .stg_rd(stg_rd), .stg_wen(stg_wen), .ld_rd(ld_rd),
      .ld_is_load(ld_is_load), .flush(flush), .fwd_sel(fwd_sel_b), .stall(stall_b),
      .perf_stall_cnt(perf_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // First stage (youngest first) that writes a nonzero register equal to the source.
   function automatic int ref_sel(input int i);
      if (!id_src_used[i]) return 0;
      for (int k = 1; k <= int'(NSTG); k++) begin
         if (stg_wen[k-1] && stg_rd[(k-1)*AW +: AW] != 0 &&
             stg_rd[(k-1)*AW +: AW] == id_src[i*AW +: AW]) return k;
      end
      return 0;
   endfunction

   function automatic bit ref_hazard();
      bit m = 0;
      for (int i = 0; i < int'(NSRC); i++)
         if (id_src_used[i] && ld_rd == id_src[i*AW +: AW]) m = 1;
      return id_valid && ld_is_load && (ld_rd != 0) && m;
   endfunction

   function automatic bit ref_stall(input int u);
      return !flush && (rem[u] > 0 || ref_hazard());
   endfunction

   task automatic check_all(input string tag);
      for (int i = 0; i < int'(NSRC); i++) begin
         check($sformatf("%s.sel_a%0d", tag, i), fwd_sel_a[i*SW +: SW], ref_sel(i));
         check($sformatf("%s.sel_b%0d", tag, i), fwd_sel_b[i*SW +: SW], ref_sel(i));
      end
      check({tag, ".stall_a"}, stall_a, ref_stall(0));
      check({tag, ".stall_b"}, stall_b, ref_stall(1));
      check({tag, ".perf_a"}, perf_a, perf[0]);
      check({tag, ".perf_b"}, perf_b, perf[1]);
   endtask

   // Advance the model across one rising edge; rem counts stall cycles still owed.
   task automatic tick();
      bit st [2];
      bit hz;
      hz = ref_hazard();
      for (int u = 0; u < 2; u++) st[u] = ref_stall(u);
      for (int u = 0; u < 2; u++) begin
         if (st[u] && perf[u] < (1 << CW) - 1) perf[u]++;
         if (flush) rem[u] = 0;
         else if (rem[u] > 0) rem[u]--;
         else if (hz) rem[u] = lat[u] - 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step(input string tag);
      @(negedge clk);
      check_all(tag);
      tick();
   endtask

   task automatic clear_inputs();
      id_src = '0; id_src_used = '0; id_valid = 0; stg_rd = '0; stg_wen = '0;
      ld_rd = '0; ld_is_load = 0; flush = 0;
   endtask

   task automatic set_load_hazard();
      ld_rd = 5'd7; ld_is_load = 1; id_valid = 1;
      id_src[AW +: AW] = 5'd7; id_src_used = 2'b10;
   endtask

   initial begin
      lat[0] = 3; lat[1] = 1;
      rem[0] = 0; rem[1] = 0; perf[0] = 0; perf[1] = 0;
      clear_inputs();
      rstn = 0;
      #12;
      check_all("reset");
      @(negedge clk); rstn = 1;
      @(posedge clk); #1;

      // Forwarding priority and the zero register
      stg_wen = 2'b11; stg_rd = {5'd5, 5'd5}; id_src = {5'd0, 5'd5}; id_src_used = 2'b01;
      step("fwd_both");
      check("fwd_both_sel0", fwd_sel_a[SW-1:0], 1);
      stg_wen = 2'b10;
      step("fwd_stg2");
      check("fwd_stg2_sel0", fwd_sel_a[SW-1:0], 2);
      id_src = '0; stg_rd = '0; stg_wen = 2'b11; id_src_used = 2'b11;
      step("fwd_zero");

      // Single load-use hazard: 3 cycles on LD_LAT=3, 1 cycle on LD_LAT=1
      clear_inputs(); set_load_hazard();
      step("ld_hz");
      id_valid = 0;
      repeat (4) step("ld_win");
      check("ld_perf_a", perf_a, 3);
      check("ld_perf_b", perf_b, 1);

      // Flush in the second stall cycle
      set_load_hazard();
      step("fl_hz");
      id_valid = 0; flush = 1;
      step("fl_flush");
      flush = 0;
      repeat (2) step("fl_after");
      check("fl_perf_a", perf_a, 4);

      // No hazard when source unused or load targets r0
      set_load_hazard(); id_src_used = 2'b00;
      repeat (2) step("nohz_unused");
      set_load_hazard(); ld_rd = 5'd0; id_src[AW +: AW] = 5'd0;
      repeat (2) step("nohz_r0");

      // Continuous hazard: back-to-back windows and saturation
      set_load_hazard();
      repeat (20) step("sat");
      check("sat_perf_b", perf_b, 15);
      check("sat_perf_a", perf_a, 15);

      // Asynchronous reset mid-window
      @(negedge clk);
      check("pre_rst_stall_a", stall_a, 1);
      #1;
      rstn = 0; id_valid = 0;
      #1;
      check("rst_stall_a", stall_a, 0);
      check("rst_perf_a", perf_a, 0);
      check("rst_perf_b", perf_b, 0);
      rem[0] = 0; rem[1] = 0; perf[0] = 0; perf[1] = 0;
      #2 rstn = 1;
      @(posedge clk); #1;
      step("post_rst");

      // Randomized traffic over a small register space to provoke matches
      for (int n = 0; n < 400; n++) begin
         id_src      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         id_src_used = 2'($urandom);
         id_valid    = 1'($urandom_range(0, 3) != 0);
         stg_rd      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         stg_wen     = 2'($urandom);
         ld_rd       = 5'($urandom_range(0, 7));
         ld_is_load  = 1'($urandom_range(0, 1));
         flush       = 1'($urandom_range(0, 7) == 0);
         step("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
